// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, funct3 size codes and the registered EX/MEM payload.
package ex_mem_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] redirect_pc;
        logic [3:0]            wmask;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [2:0]            funct3;
        logic                  misaligned;
    } ex_mem_payload_t;
endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX-side input payload, MEM-side output payload and fetch redirect.
interface ex_mem_if;
    import ex_mem_pkg::*;
    logic                  in_valid, in_ready;
    logic [DATA_WIDTH-1:0] alu_result, pc, imm, rs2_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write, mem_read, mem_write;
    logic [2:0]            funct3;
    logic                  branch, jal, jalr, flush;
    logic                  out_valid, out_ready;
    logic [DATA_WIDTH-1:0] out_result, out_wdata;
    logic [3:0]            out_wmask;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write, out_mem_read, out_mem_write;
    logic [2:0]            out_funct3;
    logic                  out_misaligned, redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    modport slave (
        input  in_valid, alu_result, pc, imm, rs2_data, rd, reg_write, mem_read, mem_write,
               funct3, branch, jal, jalr, flush, out_ready,
        output in_ready, out_valid, out_result, out_wdata, out_wmask, out_rd, out_reg_write,
               out_mem_read, out_mem_write, out_funct3, out_misaligned, redirect, redirect_pc
    );
    modport master (
        output in_valid, alu_result, pc, imm, rs2_data, rd, reg_write, mem_read, mem_write,
               funct3, branch, jal, jalr, flush, out_ready,
        input  in_ready, out_valid, out_result, out_wdata, out_wmask, out_rd, out_reg_write,
               out_mem_read, out_mem_write, out_funct3, out_misaligned, redirect, redirect_pc
    );
endinterface

// File: rtl/ex_mem_stage_store_align.sv
// store_align: lane replication, byte mask and natural-alignment check for loads/stores.
module store_align
    import ex_mem_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [1:0]            i_addr,
    input  logic [2:0]            i_funct3,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [3:0]            o_wmask,
    output logic                  o_misaligned
);
    logic w_byte, w_half;
    // anything that is not a byte or half access (including illegal codes) behaves as a word
    assign w_byte = i_funct3 == F3_B || i_funct3 == F3_BU;
    assign w_half = i_funct3 == F3_H || i_funct3 == F3_HU;
    assign o_misaligned = (i_mem_read || i_mem_write) &&
                          (w_byte ? 1'b0 : w_half ? i_addr[0] : i_addr != 2'b00);
    assign o_wdata = !i_mem_write ? i_rs2 :
                     w_byte ? {4{i_rs2[7:0]}} : w_half ? {2{i_rs2[15:0]}} : i_rs2;
    assign o_wmask = (!i_mem_write || o_misaligned) ? 4'b0000 :
                     w_byte ? 4'b0001 << i_addr : w_half ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX->MEM register with branch/jump resolution and store formatting.
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    ex_mem_if.slave  bus
);
    ex_mem_payload_t       r_pl, w_pl;
    logic                  r_valid, r_redirect;
    logic                  w_accept, w_take, w_mis;
    logic [3:0]            w_wmask;
    logic [DATA_WIDTH-1:0] w_wdata;
    store_align u_align (
        .i_rs2        (bus.rs2_data),
        .i_addr       (bus.alu_result[1:0]),
        .i_funct3     (bus.funct3),
        .i_mem_read   (bus.mem_read),
        .i_mem_write  (bus.mem_write),
        .o_wdata      (w_wdata),
        .o_wmask      (w_wmask),
        .o_misaligned (w_mis)
    );
    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_take       = bus.jal || bus.jalr || (bus.branch && bus.alu_result[0]);
    always_comb begin
        w_pl             = '0;
        w_pl.result      = (bus.jal || bus.jalr) ? bus.pc + 32'd4 : bus.alu_result;
        w_pl.wdata       = w_wdata;
        w_pl.redirect_pc = bus.jalr ? (bus.alu_result + bus.imm) & ~32'd1 : bus.pc + bus.imm;
        w_pl.wmask       = w_wmask;
        w_pl.rd          = bus.rd;
        w_pl.reg_write   = bus.reg_write;
        w_pl.mem_read    = bus.mem_read && !w_mis;
        w_pl.mem_write   = bus.mem_write && !w_mis;
        w_pl.funct3      = bus.funct3;
        w_pl.misaligned  = w_mis;
    end
    // redirect is a pulse tied to the accepting edge, so a held payload never re-fires it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pl       <= '0;
            r_valid    <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_redirect <= w_accept && w_take;
            if (bus.flush) r_valid <= 1'b0;
            else if (w_accept) begin
                r_pl    <= w_pl;
                r_valid <= 1'b1;
            end else if (bus.out_ready) r_valid <= 1'b0;
        end
    end
    assign bus.out_valid      = r_valid;
    assign bus.out_result     = r_pl.result;
    assign bus.out_wdata      = r_pl.wdata;
    assign bus.out_wmask      = r_pl.wmask;
    assign bus.out_rd         = r_pl.rd;
    assign bus.out_reg_write  = r_pl.reg_write;
    assign bus.out_mem_read   = r_pl.mem_read;
    assign bus.out_mem_write  = r_pl.mem_write;
    assign bus.out_funct3     = r_pl.funct3;
    assign bus.out_misaligned = r_pl.misaligned;
    assign bus.redirect       = r_redirect;
    assign bus.redirect_pc    = r_pl.redirect_pc;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors with hand-computed expectations for ex_mem_stage.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    ex_mem_if bus ();
    ex_mem_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic v, input logic [31:0] alu, pc, imm, rs2, input logic [4:0] rd,
                      input logic rw, mr, mw, input logic [2:0] f3, input logic br, jl, jr);
        bus.in_valid = v; bus.alu_result = alu; bus.pc = pc; bus.imm = imm; bus.rs2_data = rs2;
        bus.rd = rd; bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw; bus.funct3 = f3;
        bus.branch = br; bus.jal = jl; bus.jalr = jr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        // SW aligned
        op(1, 32'h100, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1, 3'b010, 0, 0, 0);
        step();
        chk("sw_valid", 32'(bus.out_valid), 32'd1);
        chk("sw_wdata", bus.out_wdata, 32'hDEADBEEF);
        chk("sw_wmask", 32'(bus.out_wmask), 32'hF);
        chk("sw_result", bus.out_result, 32'h100);
        chk("sw_memw", 32'(bus.out_mem_write), 32'd1);
        // SB at lane 3
        op(1, 32'h103, 0, 0, 32'h12345678, 0, 0, 0, 1, 3'b000, 0, 0, 0);
        step();
        chk("sb_wdata", bus.out_wdata, 32'h78787878);
        chk("sb_wmask", 32'(bus.out_wmask), 32'h8);
        chk("sb_mis", 32'(bus.out_misaligned), 32'd0);
        // SH at upper half
        op(1, 32'h102, 0, 0, 32'hCAFEBABE, 0, 0, 0, 1, 3'b001, 0, 0, 0);
        step();
        chk("sh_wdata", bus.out_wdata, 32'hBABEBABE);
        chk("sh_wmask", 32'(bus.out_wmask), 32'hC);
        // LW misaligned
        op(1, 32'h102, 0, 0, 0, 5'd5, 1, 1, 0, 3'b010, 0, 0, 0);
        step();
        chk("lw_mis", 32'(bus.out_misaligned), 32'd1);
        chk("lw_memr", 32'(bus.out_mem_read), 32'd0);
        chk("lw_rd", 32'(bus.out_rd), 32'd5);
        chk("lw_rw", 32'(bus.out_reg_write), 32'd1);
        // SH misaligned
        op(1, 32'h101, 0, 0, 32'h1234, 0, 0, 0, 1, 3'b001, 0, 0, 0);
        step();
        chk("shm_mis", 32'(bus.out_misaligned), 32'd1);
        chk("shm_wmask", 32'(bus.out_wmask), 32'd0);
        chk("shm_memw", 32'(bus.out_mem_write), 32'd0);
        // taken branch
        op(1, 32'd1, 32'h40, 32'hFFFFFFF8, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        step();
        chk("beq_redir", 32'(bus.redirect), 32'd1);
        chk("beq_pc", bus.redirect_pc, 32'h38);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        step();
        chk("beq_pulse", 32'(bus.redirect), 32'd0);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        // not-taken branch
        op(1, 32'd0, 32'h40, 32'hFFFFFFF8, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        step();
        chk("bnt_redir", 32'(bus.redirect), 32'd0);
        chk("bnt_valid", 32'(bus.out_valid), 32'd1);
        // JAL wrapping link and target
        op(1, 0, 32'hFFFFFFFC, 32'd8, 0, 5'd1, 1, 0, 0, 3'b000, 0, 1, 0);
        step();
        chk("jal_link", bus.out_result, 32'h0);
        chk("jal_pc", bus.redirect_pc, 32'h4);
        chk("jal_redir", 32'(bus.redirect), 32'd1);
        // JALR then stall
        op(1, 32'h201, 32'h10, 32'd2, 0, 5'd1, 1, 0, 0, 3'b000, 0, 0, 1);
        step();
        chk("jalr_pc", bus.redirect_pc, 32'h202);
        chk("jalr_link", bus.out_result, 32'h14);
        chk("jalr_redir", 32'(bus.redirect), 32'd1);
        bus.out_ready = 1'b0;
        op(1, 32'h300, 0, 0, 32'h55, 0, 0, 0, 1, 3'b010, 0, 0, 0);
        #1;
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("hold_redir", 32'(bus.redirect), 32'd0);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        step();
        step();
        chk("hold_result", bus.out_result, 32'h14);
        chk("hold_rpc", bus.redirect_pc, 32'h202);
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        step();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_result", bus.out_result, 32'h14);
        bus.flush = 1'b0;
        step();
        chk("post_valid", 32'(bus.out_valid), 32'd1);
        chk("post_result", bus.out_result, 32'h300);
        // async reset mid-transfer
        op(1, 32'h400, 0, 0, 32'hAA, 0, 0, 0, 1, 3'b010, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_result", bus.out_result, 32'd0);
        chk("arst_wmask", 32'(bus.out_wmask), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("arst_held", 32'(bus.out_valid), 32'd0);
        #1 reset = 1'b1;
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        step();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
